// File: rtl/video_stream_pkg.sv
// Shared definitions for the 17-bit tagged pixel stream: control word
// encodings, the resizer state enum and the DDA accumulator sizing helper.
package video_stream_pkg;

  localparam int STREAM_W = 17;

  localparam logic [STREAM_W-1:0] FRAME_START = 17'h10000;
  localparam logic [STREAM_W-1:0] ROW_START   = 17'h10001;
  localparam logic [STREAM_W-1:0] FRAME_END   = 17'h1FFFF;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_ROW,
    ROW_KEEP,
    ROW_DROP
  } resize_state_t;

  // Accumulator needs to hold acc + OUT, which stays below IN + OUT
  function automatic int dda_acc_width(input int in_n, input int out_n);
    return $clog2(in_n + out_n) + 1;
  endfunction

endpackage

// File: rtl/resize_dda_step.sv
// One axis of nearest-neighbour decimation: a DDA that keeps exactly OUT
// of every IN steps. keep is valid combinationally for the current step.
module resize_dda_step
  import video_stream_pkg::*;
#(
  parameter int IN  = 640,
  parameter int OUT = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic step,
  output logic keep
);

  localparam int AW = dda_acc_width(IN, OUT);
  localparam logic [AW-1:0] INIT_V = AW'(IN - OUT);
  localparam logic [AW-1:0] IN_V   = AW'(IN);
  localparam logic [AW-1:0] OUT_V  = AW'(OUT);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  assign sum  = acc + OUT_V;
  assign keep = (sum >= IN_V);

  // Starting at IN-OUT makes the very first step a keep (source index 0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= INIT_V;
    end else if (init) begin
      acc <= INIT_V;
    end else if (step) begin
      acc <= keep ? (sum - IN_V) : sum;
    end
  end

endmodule

// File: rtl/stream_resizer.sv
// Streaming nearest-neighbour downscaler for the tagged pixel stream.
// Rows are decimated by a vertical DDA stepped on row starts, pixels by a
// horizontal DDA stepped inside kept rows. One output register with a
// ready/valid handshake on both sides.
// Optional protocol checker: define STREAM_RESIZER_CHECK_EN.
module stream_resizer
  import video_stream_pkg::*;
#(
  parameter int IN_WIDTH   = 640,
  parameter int IN_HEIGHT  = 480,
  parameter int OUT_WIDTH  = 480,
  parameter int OUT_HEIGHT = 272
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scale_en,
  input  logic [STREAM_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [STREAM_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                proto_error
);

  resize_state_t state, state_next;
  logic mode_scale, mode_next;
  logic accept, is_ctrl, in_row, fwd;
  logic h_init, h_step, h_keep;
  logic v_init, v_step, v_keep;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_ctrl  = in_data[STREAM_W-1];
  assign in_row   = (state == ROW_KEEP) || (state == ROW_DROP);

  resize_dda_step #(.IN(IN_WIDTH), .OUT(OUT_WIDTH)) u_h_dda (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (h_init),
    .step  (h_step),
    .keep  (h_keep)
  );

  resize_dda_step #(.IN(IN_HEIGHT), .OUT(OUT_HEIGHT)) u_v_dda (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (v_init),
    .step  (v_step),
    .keep  (v_keep)
  );

  // Classify each accepted word: forward or drop, DDA steps, next state
  always_comb begin
    state_next = state;
    mode_next  = mode_scale;
    fwd        = 1'b0;
    h_init     = 1'b0;
    h_step     = 1'b0;
    v_init     = 1'b0;
    v_step     = 1'b0;
    if (accept) begin
      if (in_data == FRAME_START) begin
        fwd        = 1'b1;
        mode_next  = scale_en;
        h_init     = 1'b1;
        v_init     = 1'b1;
        state_next = WAIT_ROW;
      end else if (in_data == ROW_START) begin
        if (state == WAIT_FRAME) begin
          fwd = !mode_scale;
        end else if (!mode_scale) begin
          fwd        = 1'b1;
          state_next = ROW_KEEP;
        end else begin
          v_step = 1'b1;
          fwd    = v_keep;
          if (v_keep) begin
            h_init     = 1'b1;
            state_next = ROW_KEEP;
          end else begin
            state_next = ROW_DROP;
          end
        end
      end else if (in_data == FRAME_END) begin
        fwd        = !mode_scale || (state != WAIT_FRAME);
        state_next = WAIT_FRAME;
      end else if (is_ctrl) begin
        fwd = !mode_scale;
      end else if (!mode_scale) begin
        fwd = 1'b1;
      end else if (state == ROW_KEEP) begin
        h_step = 1'b1;
        fwd    = h_keep;
      end
    end
  end

  // State and scaling mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FRAME;
      mode_scale <= 1'b1;
    end else begin
      state      <= state_next;
      mode_scale <= mode_next;
    end
  end

  // Output register: load on a forwarded word, empty when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && fwd) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_RESIZER_CHECK_EN
  localparam int PW = $clog2(IN_WIDTH + 2);
  localparam int RW = $clog2(IN_HEIGHT + 2);

  logic [PW-1:0] pix_cnt;
  logic [RW-1:0] row_cnt;
  logic          violation;

  // Detect malformed rows/frames from the accepted word and the counters
  always_comb begin
    violation = 1'b0;
    if (accept) begin
      if (in_data == ROW_START) begin
        violation = (state == WAIT_FRAME) ||
                    (in_row && (pix_cnt != PW'(IN_WIDTH)));
      end else if (in_data == FRAME_END) begin
        violation = (state == WAIT_FRAME) ||
                    (in_row && (pix_cnt != PW'(IN_WIDTH))) ||
                    (row_cnt != RW'(IN_HEIGHT));
      end else if (!is_ctrl) begin
        violation = !in_row;
      end
    end
  end

  // Saturating pixel/row counters and the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      row_cnt     <= '0;
      proto_error <= 1'b0;
    end else begin
      proto_error <= proto_error || violation;
      if (accept) begin
        if (in_data == FRAME_START) begin
          pix_cnt <= '0;
          row_cnt <= '0;
        end else if (in_data == ROW_START) begin
          pix_cnt <= '0;
          if (state != WAIT_FRAME && row_cnt != RW'(IN_HEIGHT + 1)) begin
            row_cnt <= row_cnt + 1'b1;
          end
        end else if (!is_ctrl && in_row && pix_cnt != PW'(IN_WIDTH + 1)) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign proto_error = 1'b0;
`endif

endmodule

// File: tb/tb_stream_resizer.sv
// Self-checking bench for stream_resizer: a small 8x4->6x2 instance and a
// 640x480->480x272 instance share the stimulus; a queue-based reference
// model derives the kept rows/columns from ceil(k*IN/OUT).
module tb_stream_resizer;
  import video_stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, scale_en, in_valid, out_ready, sel;
  logic [16:0] in_data;
  logic ir_s, ov_s, pe_s, ir_l, ov_l, pe_l;
  logic [16:0] od_s, od_l;
  logic in_ready_m, out_valid_m;
  logic [16:0] out_data_m;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  bit bp = 0;
  logic [16:0] got[$];
  logic [16:0] exp_q[$];
  logic [16:0] src[$];
  logic [16:0] pix[$];
  logic prev_stall = 1'b0;
  logic [16:0] prev_data = '0;

  stream_resizer #(.IN_WIDTH(8), .IN_HEIGHT(4), .OUT_WIDTH(6), .OUT_HEIGHT(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .scale_en(scale_en),
    .in_data(in_data), .in_valid(in_valid && !sel), .in_ready(ir_s),
    .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready), .proto_error(pe_s)
  );

  stream_resizer #(.IN_WIDTH(640), .IN_HEIGHT(480), .OUT_WIDTH(480), .OUT_HEIGHT(272)) dut_l (
    .clk(clk), .rst_n(rst_n), .scale_en(scale_en),
    .in_data(in_data), .in_valid(in_valid && sel), .in_ready(ir_l),
    .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready), .proto_error(pe_l)
  );

  assign in_ready_m  = sel ? ir_l : ir_s;
  assign out_valid_m = sel ? ov_l : ov_s;
  assign out_data_m  = sel ? od_l : od_s;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Collect transferred words and check stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("stall_stable", 32'(out_data_m), 32'(prev_data));
      if (out_valid_m && out_ready) got.push_back(out_data_m);
      prev_stall = out_valid_m && !out_ready;
      prev_data  = out_data_m;
    end
  end

  task automatic nextReady();
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic applyStimulus(input logic [16:0] w);
    int n;
    logic took;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    took = 1'b0;
    while (!took && n < 200) begin
      @(negedge clk);
      took = in_ready_m;
      @(posedge clk);
      #1;
      n++;
      nextReady();
    end
    in_valid = 1'b0;
    if (!took) checkOutput("accept_timeout", 32'd0, 32'd1);
    else accepted++;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      nextReady();
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference model: source row/col r is kept iff r == ceil(k*IN/OUT) for some k < OUT
  task automatic buildFrame(input int w, input int h, input int in_w, input int in_h,
                            input int out_w, input int out_h, input bit scale);
    bit kr[];
    bit kc[];
    int idx;
    logic [16:0] p;
    kr = new[h];
    kc = new[w];
    for (int k = 0; k < out_h; k++) begin
      idx = (k * in_h + out_h - 1) / out_h;
      if (idx < h) kr[idx] = 1'b1;
    end
    for (int k = 0; k < out_w; k++) begin
      idx = (k * in_w + out_w - 1) / out_w;
      if (idx < w) kc[idx] = 1'b1;
    end
    src.delete();
    pix.delete();
    exp_q.delete();
    src.push_back(FRAME_START);
    for (int r = 0; r < h; r++) begin
      src.push_back(ROW_START);
      for (int c = 0; c < w; c++) begin
        p = 17'($urandom) & 17'h0FFFF;
        src.push_back(p);
        pix.push_back(p);
      end
    end
    src.push_back(FRAME_END);
    if (!scale) begin
      foreach (src[i]) exp_q.push_back(src[i]);
    end else begin
      exp_q.push_back(FRAME_START);
      for (int r = 0; r < h; r++) begin
        if (kr[r]) begin
          exp_q.push_back(ROW_START);
          for (int c = 0; c < w; c++)
            if (kc[c]) exp_q.push_back(pix[r * w + c]);
        end
      end
      exp_q.push_back(FRAME_END);
    end
  endtask

  task automatic compareQueues(input string tag);
    checkOutput({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size())
        checkOutput($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic runFrame(input int w, input int h, input int in_w, input int in_h,
                          input int out_w, input int out_h, input bit scale, input string tag);
    buildFrame(w, h, in_w, in_h, out_w, out_h, scale);
    got.delete();
    foreach (src[i]) applyStimulus(src[i]);
    drain(30);
    compareQueues(tag);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = '0;
    scale_en = 1'b1; out_ready = 1'b1;
    #12;
    checkOutput("rst_out_valid", 32'(ov_s), 32'd0);
    checkOutput("rst_out_data", 32'(od_s), 32'd0);
    checkOutput("rst_proto_error", 32'(pe_s), 32'd0);
    checkOutput("rst_in_ready", 32'(ir_s), 32'd1);
    checkOutput("rst_out_valid_l", 32'(ov_l), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runFrame(8, 4, 8, 4, 6, 2, 1'b1, "scale");

    scale_en = 1'b0;
    runFrame(8, 4, 8, 4, 6, 2, 1'b0, "pass");
    scale_en = 1'b1;

    bp = 1'b1;
    runFrame(8, 4, 8, 4, 6, 2, 1'b1, "backpressure");
    bp = 1'b0;

    buildFrame(8, 4, 8, 4, 6, 2, 1'b1);
    accepted = 0;
    for (int i = 0; i < 10; i++) applyStimulus(src[i]);
    checkOutput("pre_rst_accepted", 32'(accepted), 32'd10);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(ov_s), 32'd0);
    checkOutput("midrst_out_data", 32'(od_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runFrame(8, 4, 8, 4, 6, 2, 1'b1, "after_rst");

    sel = 1'b1;
    runFrame(640, 40, 640, 480, 480, 272, 1'b1, "big");
    sel = 1'b0;

`ifdef STREAM_RESIZER_CHECK_EN
    applyStimulus(FRAME_START);
    applyStimulus(ROW_START);
    for (int c = 0; c < 8; c++) applyStimulus(17'(c));
    applyStimulus(ROW_START);
    for (int c = 0; c < 7; c++) applyStimulus(17'(c));
    checkOutput("perr_before", 32'(pe_s), 32'd0);
    applyStimulus(ROW_START);
    checkOutput("perr_set", 32'(pe_s), 32'd1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) applyStimulus(17'(c));
      applyStimulus(ROW_START);
    end
    for (int c = 0; c < 8; c++) applyStimulus(17'(c));
    applyStimulus(FRAME_END);
    drain(10);
    runFrame(8, 4, 8, 4, 6, 2, 1'b1, "after_err");
    checkOutput("perr_sticky", 32'(pe_s), 32'd1);
`else
    checkOutput("proto_off_s", 32'(pe_s), 32'd0);
    checkOutput("proto_off_l", 32'(pe_l), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
